// File: rtl/display_scan_mux.sv
// display_scan_mux
// Time-multiplexed driver for a multi-digit 7-segment style display.
// It holds N_CH segment codes and scans them one at a time onto a shared
// segment bus. A one-hot digit enable selects the lit digit. Channels that
// are masked off are skipped. frame_tick pulses for one cycle whenever the
// scan wraps.
//
// Parameters:
//   N_CH         number of channels/digits (2..16)
//   SEG_W        width of one segment code
//   DIV          clock cycles per digit slot (>= 2)
//   IDX_W        width of ch_idx, derived from N_CH
//   BLINK_FRAMES frames per blink half-period (only with BLINK_EN)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   scan enable; low freezes the scan and blanks the outputs
//   seg_in     in   packed codes, channel k at [k*SEG_W +: SEG_W]
//   ch_mask    in   1 = channel k takes part in the scan
//   blink_mask in   1 = channel k blinks (only with BLINK_EN)
//   seg_out    out  registered segment code of the active channel
//   an_out     out  registered one-hot digit enable, active-high
//   ch_idx     out  registered index of the current slot's channel
//   frame_tick out  one-cycle pulse after a slot advance that wraps
//
// Optional feature macro: BLINK_EN adds the blink_mask port, the
// BLINK_FRAMES parameter, a frame counter and a blink phase. While the phase
// is high, blinking channels show a blank code, but their digit enable is
// still driven.

module display_scan_mux #(
  parameter int N_CH  = 4,
  parameter int SEG_W = 7,
  parameter int DIV   = 50000,
`ifdef BLINK_EN
  parameter int BLINK_FRAMES = 256,
`endif
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_CH*SEG_W-1:0]   seg_in,
  input  logic [N_CH-1:0]         ch_mask,
`ifdef BLINK_EN
  input  logic [N_CH-1:0]         blink_mask,
`endif
  output logic [SEG_W-1:0]        seg_out,
  output logic [N_CH-1:0]         an_out,
  output logic [IDX_W-1:0]        ch_idx,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [N_CH-1:0]  ONE_HOT0 = N_CH'(1);

  // Scan state
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  // Next-state and next-output values
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx_next;
  logic [SEG_W-1:0] seg_next;
  logic [N_CH-1:0]  an_next;
  logic             tick_next;

  // Helpers for the next-enabled-channel search
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] search_idx;
  logic             found;
  logic             advance;
  logic             show;

`ifdef BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0] frame_cnt;
  logic              phase;
`endif

  // Search order starts at idx+1 and ends at idx itself. That way a single
  // enabled channel re-selects itself, and the advance still counts as a
  // wrap.
  always_comb begin
    found      = 1'b0;
    search_idx = idx;
    cand_idx   = idx;
    for (int k = 1; k <= N_CH; k++) begin
      cand_idx = IDX_W'((int'(idx) + k) % N_CH);
      if (!found && ch_mask[cand_idx]) begin
        found      = 1'b1;
        search_idx = cand_idx;
      end
    end
  end

  // Prescaler, slot advance and output selection.
  // The outputs always reflect the idx held before this edge. The visible
  // digit therefore changes one cycle after the advance edge.
  always_comb begin
    cnt_next  = cnt;
    idx_next  = idx;
    tick_next = 1'b0;
    seg_next  = '0;
    an_next   = '0;

    advance = en && (cnt == CNT_LAST);
    show    = en && ch_mask[idx];

    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end

    if (advance && found) begin
      idx_next  = search_idx;
      tick_next = (search_idx <= idx);
    end

    if (show) begin
      seg_next = seg_in[int'(idx)*SEG_W +: SEG_W];
      an_next  = ONE_HOT0 << idx;
`ifdef BLINK_EN
      if (phase && blink_mask[idx]) begin
        seg_next = '0;
      end
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      seg_out    <= '0;
      an_out     <= '0;
      ch_idx     <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      seg_out    <= seg_next;
      an_out     <= an_next;
      ch_idx     <= idx;
      frame_tick <= tick_next;
    end
  end

`ifdef BLINK_EN
  // Blink phase. It toggles every BLINK_FRAMES frame ticks and freezes
  // while scanning is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (en && frame_tick) begin
      if (frame_cnt == FCNT_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
